vlog_burst_requester: RTL and testbench

- Upstream requester front-end for the two-port grant arbiter (vlog_fsm_2); one instance drives one req/gnt pair.
- Accepts a burst command (base address + length) over valid/ready, raises req, and holds it through the grant.
- Emits one address beat per granted cycle, then drops req and waits for gnt to fall before taking the next command.
- Bounds the wait for grant with a timeout, after which it abandons the command and flags an error.

---
 rtl/vlog_burst_req_pkg.sv | 20 ++
 rtl/vlog_wait_counter.sv | 31 +++
 rtl/vlog_burst_requester.sv | 120 ++++++++++++
 tb/tb_vlog_burst_requester.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlog_burst_req_pkg.sv
// Shared constants and state encoding for the burst requester slice.
package vlog_burst_req_pkg;

  // Default widths and grant-wait bound.
  localparam int ADDR_W_DEF  = 8;
  localparam int LEN_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 15;

  // Wait counter width; wide enough for the largest legal TIMEOUT (255).
  localparam int WAIT_CNT_W = 8;

  // One-hot controller states.
  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    REQ     = 4'b0010,
    XFER    = 4'b0100,
    RELEASE = 4'b1000
  } state_t;

endpackage

// File: rtl/vlog_wait_counter.sv
// Clearable up-counter with a terminal-count flag, used to bound the grant wait.
module vlog_wait_counter
  import vlog_burst_req_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [WAIT_CNT_W-1:0] r_cnt;

  // Count waiting cycles; clear has priority over enable.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + WAIT_CNT_W'(1);
    end
  end

  // Terminal count: this is the last waiting cycle allowed.
  assign o_tc = (r_cnt == WAIT_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/vlog_burst_requester.sv
// Requester front-end: takes a burst command, holds req through the grant,
// emits one address beat per granted cycle, and waits for gnt to fall before
// accepting the next command. A bounded grant wait aborts with err_timeout.
module vlog_burst_requester
  import vlog_burst_req_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              req,
  input  logic              gnt,
  output logic              beat_valid,
  output logic [ADDR_W-1:0] beat_addr,
  output logic              done,
  output logic              err_timeout
);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_beat_cnt;
  logic               r_req;
  logic               r_done;
  logic               r_err;

  logic               w_accept;
  logic               w_wait_en;
  logic               w_wait_tc;
  logic               w_last_beat;

  assign cmd_ready   = (r_state == IDLE);
  assign w_accept    = cmd_valid & cmd_ready;
  assign w_wait_en   = (r_state == REQ) & ~gnt & ~w_wait_tc;
  assign w_last_beat = (r_beat_cnt == r_len);

  // Grant-wait bound, restarted for every accepted command.
  vlog_wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clr   (w_accept),
    .i_en    (w_wait_en),
    .o_tc    (w_wait_tc)
  );

  // Controller FSM with registered req/done/err_timeout.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr  <= cmd_addr;
            r_len   <= cmd_len;
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          // A grant on the expiry cycle still wins over the timeout.
          if (gnt) begin
            r_beat_cnt <= '0;
            r_state    <= XFER;
          end else if (w_wait_tc) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= RELEASE;
          end
        end
        XFER: begin
          // Count only granted beats; a gnt drop simply stalls the burst.
          if (gnt) begin
            if (w_last_beat) begin
              r_req   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= RELEASE;
            end else begin
              r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            end
          end
        end
        RELEASE: begin
          // Hold off until the arbiter has withdrawn its grant.
          if (!gnt) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign req         = r_req;
  assign done        = r_done;
  assign err_timeout = r_err;
  assign beat_valid  = (r_state == XFER) & gnt;
  assign beat_addr   = r_addr + ADDR_W'(r_beat_cnt);

endmodule

// File: tb/tb_vlog_burst_requester.sv
// Bench for vlog_burst_requester: an arbiter model drives gnt, a monitor
// collects beats and pulses per command, and each scenario compares them with
// the burst expected from the command (base + i mod 256 for i = 0..len).
module tb_vlog_burst_requester;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       req;
  logic       gnt;
  logic       beat_valid;
  logic [7:0] beat_addr;
  logic       done;
  logic       err_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-command observations.
  logic [7:0] obs_beats[$];
  int obs_req_cycles, obs_done, obs_err, obs_done_req, obs_ready_gnt;

  // Arbiter model: 0 = registered follower (gnt tracks req one cycle late,
  // optional stalls), 1 = never grant, 2 = grant combinationally once req has
  // been seen high arb_n times.
  int arb_mode = 0;
  int arb_n = 0;
  int req_seen = 0;
  int stall_pct = 0;
  int stall_left = 0;
  int stall_at = -1;
  bit prev_req = 1'b0;

  always #5 clock = ~clock;

  vlog_burst_requester dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .req         (req),
    .gnt         (gnt),
    .beat_valid  (beat_valid),
    .beat_addr   (beat_addr),
    .done        (done),
    .err_timeout (err_timeout)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    obs_beats.delete();
    obs_req_cycles = 0;
    obs_done = 0;
    obs_err = 0;
    obs_done_req = 0;
    obs_ready_gnt = 0;
    req_seen = 0;
  endtask

  // One cycle: sample outputs at the falling edge, then drive gnt for the next edge.
  task automatic step();
    @(negedge clock);
    if (req) obs_req_cycles++;
    if (beat_valid) obs_beats.push_back(beat_addr);
    if (done) begin
      obs_done++;
      if (req) obs_done_req++;
    end
    if (err_timeout) obs_err++;
    if (cmd_ready && gnt) obs_ready_gnt++;
    case (arb_mode)
      0: begin
        if (stall_left > 0) begin
          gnt = 1'b0;
          stall_left--;
        end else if (stall_at >= 0 && obs_beats.size() == stall_at) begin
          gnt = 1'b0;
          stall_left = 1;
          stall_at = -1;
        end else if (prev_req && $urandom_range(99) < stall_pct) begin
          gnt = 1'b0;
          stall_left = $urandom_range(2);
        end else begin
          gnt = prev_req;
        end
      end
      1: gnt = 1'b0;
      default: begin
        if (req) req_seen++;
        gnt = req && (req_seen >= arb_n);
      end
    endcase
    prev_req = req;
  endtask

  // Offer one command from IDLE, keep cmd_valid high with junk during the
  // burst, and run until cmd_ready returns (bounded).
  task automatic run_burst(input logic [7:0] a, input logic [3:0] l, output bit ok);
    clear_obs();
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    step();
    cmd_addr = 8'($urandom);
    cmd_len  = 4'($urandom);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL idle_return: cmd_ready still 0 after 200 cycles, required 1");
    end
  endtask

  // Reference: burst of l+1 beats at a, a+1, ... modulo 256.
  function automatic bit beats_match(input logic [7:0] a, input int l);
    if (obs_beats.size() != l + 1) return 1'b0;
    foreach (obs_beats[i])
      if (obs_beats[i] !== 8'((int'(a) + i) % 256)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; gnt = 1'b0;
    arb_mode = 1;
    step(); step();
    n_cmp++;
    if (req !== 1'b0 || done !== 1'b0 || err_timeout !== 1'b0 || beat_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: req=%b done=%b err=%b beat_valid=%b, required all 0",
               req, done, err_timeout, beat_valid);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
    end
    reset_n = 1'b1;
    step();
    n_cmp++;
    if (cmd_ready !== 1'b1 || req !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset: cmd_ready=%b req=%b, required 1/0", cmd_ready, req);
    end
    arb_mode = 0;
  endtask

  task automatic test_single();
    bit ok;
    run_burst(8'h10, 4'd0, ok);
    n_cmp++;
    if (!beats_match(8'h10, 0)) begin
      n_bad++;
      $display("FAIL single_beats: got %0d beats, required 1 at 10", obs_beats.size());
    end
    n_cmp++;
    if (obs_done != 1 || obs_err != 0) begin
      n_bad++;
      $display("FAIL single_pulses: done=%0d err=%0d, required 1/0", obs_done, obs_err);
    end
    n_cmp++;
    if (obs_done_req != 0) begin
      n_bad++;
      $display("FAIL single_req_drop: req high with done %0d times, required 0", obs_done_req);
    end
    n_cmp++;
    if (obs_ready_gnt != 0) begin
      n_bad++;
      $display("FAIL single_release: cmd_ready with gnt %0d times, required 0", obs_ready_gnt);
    end
  endtask

  task automatic test_burst(input string nm, input logic [7:0] a, input logic [3:0] l);
    bit ok;
    run_burst(a, l, ok);
    n_cmp++;
    if (!beats_match(a, int'(l))) begin
      n_bad++;
      $display("FAIL %s_beats: got %0d beats (first %h), required %0d from %h",
               nm, obs_beats.size(), (obs_beats.size() > 0) ? obs_beats[0] : 8'h00, int'(l) + 1, a);
    end
    n_cmp++;
    if (obs_done != 1 || obs_err != 0 || obs_ready_gnt != 0) begin
      n_bad++;
      $display("FAIL %s_pulses: done=%0d err=%0d ready_gnt=%0d, required 1/0/0",
               nm, obs_done, obs_err, obs_ready_gnt);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    arb_mode = 1;
    run_burst(8'h33, 4'd2, ok);
    n_cmp++;
    if (obs_req_cycles != 15) begin
      n_bad++;
      $display("FAIL timeout_req_cycles: req high %0d cycles, required 15", obs_req_cycles);
    end
    n_cmp++;
    if (obs_err != 1 || obs_done != 0) begin
      n_bad++;
      $display("FAIL timeout_pulses: err=%0d done=%0d, required 1/0", obs_err, obs_done);
    end
    n_cmp++;
    if (obs_beats.size() != 0) begin
      n_bad++;
      $display("FAIL timeout_beats: got %0d beats, required 0", obs_beats.size());
    end
    arb_mode = 0;
  endtask

  task automatic test_stall();
    stall_at = 2;
    test_burst("stall", 8'h40, 4'd3);
    n_cmp++;
    if (stall_at != -1) begin
      n_bad++;
      $display("FAIL stall_applied: stall marker %0d, required -1 (gnt drop injected)", stall_at);
    end
    stall_at = -1;
  endtask

  task automatic test_race();
    bit ok;
    // Grant on the final allowed wait cycle: gnt beats the timeout.
    arb_mode = 2; arb_n = 15;
    test_burst("race", 8'h77, 4'd1);
    // One cycle later is too late: the command is abandoned.
    arb_n = 16;
    run_burst(8'h78, 4'd1, ok);
    n_cmp++;
    if (obs_err != 1 || obs_beats.size() != 0) begin
      n_bad++;
      $display("FAIL late_grant: err=%0d beats=%0d, required 1/0", obs_err, obs_beats.size());
    end
    arb_mode = 0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] a;
    a = 8'($urandom);
    clear_obs();
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = 4'd7;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 50 && obs_beats.size() < 2; i++) step();
    n_cmp++;
    if (obs_beats.size() != 2) begin
      n_bad++;
      $display("FAIL rst_mid_setup: got %0d beats before reset, required 2", obs_beats.size());
    end
    reset_n = 1'b0;
    step();
    n_cmp++;
    if (req !== 1'b0 || done !== 1'b0 || err_timeout !== 1'b0 || obs_done != 0 || obs_err != 0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: req=%b done=%b err=%b pulses=%0d/%0d, required all 0",
               req, done, err_timeout, obs_done, obs_err);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_ready: cmd_ready=%b, required 1", cmd_ready);
    end
    reset_n = 1'b1;
    step();
    test_burst("rst_restart", 8'h5A, 4'd2);
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [3:0] l;
    stall_pct = 25;
    for (int k = 0; k < 20; k++) begin
      a = 8'($urandom);
      l = 4'($urandom);
      test_burst("random", a, l);
    end
    stall_pct = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst("four", 8'h20, 4'd3);
    test_burst("wrap", 8'hFE, 4'd3);
    test_burst("max_len", 8'hF8, 4'd15);
    test_timeout();
    test_stall();
    test_race();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
